// File: rtl/rv_lsu_stage.sv
// rtl/rv_lsu_stage.sv - MEM stage / load-store unit between EX/MEM and MEM/WB
//
// Optional feature macro: RV_LSU_MISALIGN_TRAP_EN (misaligned access detection)
//
// Ports:
//   i_lsu_clk, i_lsu_rst          clock, synchronous active-high reset
//   i_lsu_valid .. i_lsu_rf_wd_pre EX->MEM instruction fields
//   o_lsu_stall                    freeze IF..EX while a memory op is outstanding
//   o_lsu_rf_rd_fwd                non-load result forwarded to EX (combinational)
//   o_lsu_wb_*                     MEM/WB register outputs
//   o_lsu_dmem_* / i_lsu_dmem_*    req/gnt/rvalid data-memory port
//   o_lsu_misalign                 one-cycle misalign flag (only with RV_LSU_MISALIGN_TRAP_EN)
module rv_lsu_stage #(
  parameter int XLEN = 32
) (
  input  logic              i_lsu_clk,
  input  logic              i_lsu_rst,
  input  logic              i_lsu_valid,
  input  logic              i_lsu_is_load,
  input  logic              i_lsu_dmem_we,
  input  logic [XLEN-1:0]   i_lsu_alu_res,
  input  logic [XLEN-1:0]   i_lsu_dmem_wd,
  input  logic [2:0]        i_lsu_bytectrl,
  input  logic              i_lsu_rf_we,
  input  logic [4:0]        i_lsu_rf_wa,
  input  logic [XLEN-1:0]   i_lsu_rf_wd_pre,
  output logic              o_lsu_stall,
  output logic [XLEN-1:0]   o_lsu_rf_rd_fwd,
  output logic              o_lsu_wb_valid,
  output logic              o_lsu_wb_rf_we,
  output logic [4:0]        o_lsu_wb_rf_wa,
  output logic [XLEN-1:0]   o_lsu_wb_rf_wd,
  output logic              o_lsu_dmem_req,
  input  logic              i_lsu_dmem_gnt,
  output logic [XLEN-1:0]   o_lsu_dmem_a,
  output logic              o_lsu_dmem_we,
  output logic [XLEN/8-1:0] o_lsu_dmem_be,
  output logic [XLEN-1:0]   o_lsu_dmem_wd,
  input  logic              i_lsu_dmem_rvalid,
  input  logic [XLEN-1:0]   i_lsu_dmem_rd
`ifdef RV_LSU_MISALIGN_TRAP_EN
  ,
  output logic              o_lsu_misalign
`endif
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int NH   = NB / 2;
  localparam int NW   = NB / 4;

  typedef enum logic {IDLE, RSP} state_t;

  state_t            state_q, state_d;
  logic [OFFW-1:0]   off, off_q;
  logic [2:0]        bctl_q;
  logic              mop, mis_op;
  logic              req, stall, done, load_done, mis_ev;
  logic [NB-1:0]     be_base;
  logic [XLEN-1:0]   wd_rep;
  logic [XLEN-1:0]   sh, fld, ld_ext;
  logic [1:0]        sz_eff;
  logic [6:0]        ext_amt;

  assign mop = i_lsu_valid & (i_lsu_is_load | i_lsu_dmem_we);
  assign off = i_lsu_alu_res[OFFW-1:0];

`ifdef RV_LSU_MISALIGN_TRAP_EN
  logic [OFFW-1:0] sz_mask;
  logic            mis_q;

  // Byte-offset bits that must be zero for the access size; D folds to W when XLEN=32.
  always_comb begin
    sz_mask = '0;
    case (i_lsu_bytectrl[1:0])
      2'b00:   sz_mask = OFFW'(0);
      2'b01:   sz_mask = OFFW'(1);
      2'b10:   sz_mask = OFFW'(3);
      default: sz_mask = OFFW'(7);
    endcase
  end
  assign mis_op         = mop & (|(off & sz_mask));
  assign o_lsu_misalign = mis_q;
`else
  assign mis_op = 1'b0;
`endif

  // Store lane generation: base enable shifted into place, data replicated to every lane.
  always_comb begin
    be_base = '0;
    wd_rep  = i_lsu_dmem_wd;
    case (i_lsu_bytectrl[1:0])
      2'b00: begin
        be_base = NB'(1);
        wd_rep  = {NB{i_lsu_dmem_wd[7:0]}};
      end
      2'b01: begin
        be_base = NB'(3);
        wd_rep  = {NH{i_lsu_dmem_wd[15:0]}};
      end
      2'b10: begin
        be_base = NB'(15);
        wd_rep  = {NW{i_lsu_dmem_wd[31:0]}};
      end
      default: begin
        be_base = NB'(255);
        wd_rep  = i_lsu_dmem_wd;
      end
    endcase
  end

  assign o_lsu_dmem_a    = {i_lsu_alu_res[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign o_lsu_dmem_be   = be_base << off;
  assign o_lsu_dmem_wd   = wd_rep;
  assign o_lsu_dmem_req  = req;
  assign o_lsu_dmem_we   = req & i_lsu_dmem_we & ~i_lsu_is_load;
  assign o_lsu_stall     = stall;
  assign o_lsu_rf_rd_fwd = i_lsu_rf_wd_pre;

  // Load extraction: move the addressed field to bit 0, then push it to the top and
  // shift back down, logically or arithmetically, to zero- or sign-extend in one step.
  assign sh = i_lsu_dmem_rd >> {off_q, 3'b000};

  always_comb begin
    sz_eff = bctl_q[1:0];
    if (XLEN == 32 && sz_eff == 2'b11) sz_eff = 2'b10;
    ext_amt = 7'(XLEN) - (7'd8 << sz_eff);
    fld     = sh << ext_amt;
    ld_ext  = bctl_q[2] ? (fld >> ext_amt) : XLEN'($signed(fld) >>> ext_amt);
  end

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    load_done = 1'b0;
    mis_ev    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_lsu_valid) begin
          if (!mop) begin
            done = 1'b1;
          end else if (mis_op) begin
            mis_ev = 1'b1;
          end else begin
            req = 1'b1;
            if (!i_lsu_dmem_gnt) begin
              stall = 1'b1;
            end else if (i_lsu_is_load) begin
              stall   = 1'b1;
              state_d = RSP;
            end else begin
              done = 1'b1;
            end
          end
        end
      end
      RSP: begin
        stall = ~i_lsu_dmem_rvalid;
        if (i_lsu_dmem_rvalid) begin
          done      = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk) begin
    if (i_lsu_rst) begin
      state_q        <= IDLE;
      off_q          <= '0;
      bctl_q         <= '0;
      o_lsu_wb_valid <= 1'b0;
      o_lsu_wb_rf_we <= 1'b0;
      o_lsu_wb_rf_wa <= '0;
      o_lsu_wb_rf_wd <= '0;
`ifdef RV_LSU_MISALIGN_TRAP_EN
      mis_q          <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (req && i_lsu_dmem_gnt && i_lsu_is_load) begin
        off_q  <= off;
        bctl_q <= i_lsu_bytectrl;
      end
      o_lsu_wb_valid <= done | mis_ev;
      o_lsu_wb_rf_we <= done & i_lsu_rf_we;
      if (done) begin
        o_lsu_wb_rf_wa <= i_lsu_rf_wa;
        o_lsu_wb_rf_wd <= load_done ? ld_ext : i_lsu_rf_wd_pre;
      end
`ifdef RV_LSU_MISALIGN_TRAP_EN
      mis_q <= mis_ev;
`endif
    end
  end

endmodule

// File: tb/tb_rv_lsu_stage.sv
// tb/tb_rv_lsu_stage.sv - scoreboard bench for rv_lsu_stage (XLEN=32)
module tb_rv_lsu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, is_load = 1'b0, st = 1'b0;
  logic [31:0] alu_res = '0, st_wd = '0, wd_pre = '0, rdata = '0;
  logic [2:0]  bctl = '0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_wa = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;

  logic        stall, wb_valid, wb_rf_we, req, dm_we;
  logic [31:0] fwd, wb_rf_wd, dm_a, dm_wd;
  logic [4:0]  wb_rf_wa;
  logic [3:0]  dm_be;
`ifdef RV_LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  rv_lsu_stage #(.XLEN(32)) dut (
    .i_lsu_clk(clk), .i_lsu_rst(rst), .i_lsu_valid(valid), .i_lsu_is_load(is_load),
    .i_lsu_dmem_we(st), .i_lsu_alu_res(alu_res), .i_lsu_dmem_wd(st_wd),
    .i_lsu_bytectrl(bctl), .i_lsu_rf_we(rf_we), .i_lsu_rf_wa(rf_wa),
    .i_lsu_rf_wd_pre(wd_pre), .o_lsu_stall(stall), .o_lsu_rf_rd_fwd(fwd),
    .o_lsu_wb_valid(wb_valid), .o_lsu_wb_rf_we(wb_rf_we), .o_lsu_wb_rf_wa(wb_rf_wa),
    .o_lsu_wb_rf_wd(wb_rf_wd), .o_lsu_dmem_req(req), .i_lsu_dmem_gnt(gnt),
    .o_lsu_dmem_a(dm_a), .o_lsu_dmem_we(dm_we), .o_lsu_dmem_be(dm_be),
    .o_lsu_dmem_wd(dm_wd), .i_lsu_dmem_rvalid(rvalid), .i_lsu_dmem_rd(rdata)
`ifdef RV_LSU_MISALIGN_TRAP_EN
    , .o_lsu_misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mis;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        rst_at_edge = 1'b0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rst_at_edge <= rst;

  // Monitor: every cycle the MEM/WB register is either a bubble holding its last
  // value, a reset image, or the next entry from the scoreboard.
  always @(negedge clk) begin
    wb_exp_t e;
    if (rst_at_edge) begin
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_wb_we", {31'b0, wb_rf_we}, 32'd0);
      chk("rst_wb_wa", {27'b0, wb_rf_wa}, 32'd0);
      chk("rst_wb_wd", wb_rf_wd, 32'd0);
      last_wa = '0;
      last_wd = '0;
    end else if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: got wa=%0d wd=0x%0h expected no entry", wb_rf_wa, wb_rf_wd);
      end else begin
        e = exp_q.pop_front();
        if (e.mis) begin
          e.wa = last_wa;
          e.wd = last_wd;
        end
        chk("wb_we", {31'b0, wb_rf_we}, {31'b0, e.we});
        chk("wb_wa", {27'b0, wb_rf_wa}, {27'b0, e.wa});
        chk("wb_wd", wb_rf_wd, e.wd);
`ifdef RV_LSU_MISALIGN_TRAP_EN
        chk("wb_misalign", {31'b0, misalign}, {31'b0, e.mis});
`endif
        last_wa = e.wa;
        last_wd = e.wd;
      end
    end else begin
      chk("bubble_valid", {31'b0, wb_valid}, 32'd0);
      chk("bubble_we", {31'b0, wb_rf_we}, 32'd0);
      chk("bubble_wa_hold", {27'b0, wb_rf_wa}, {27'b0, last_wa});
      chk("bubble_wd_hold", wb_rf_wd, last_wd);
    end
  end

  task automatic idle();
    valid = 1'b0; is_load = 1'b0; st = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    tick();
  endtask

  task automatic alu_op(input logic [4:0] wa, input logic [31:0] pre);
    valid = 1'b1; is_load = 1'b0; st = 1'b0; rf_we = 1'b1; rf_wa = wa; wd_pre = pre;
    exp_q.push_back('{we: 1'b1, wa: wa, wd: pre, mis: 1'b0});
    @(negedge clk);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    chk("alu_req", {31'b0, req}, 32'd0);
    chk("alu_fwd", fwd, pre);
    tick();
  endtask

  // gd: cycles of !gnt before the grant cycle; rl: cycles from grant to rvalid.
  task automatic mem_op(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] bc, input logic [4:0] wa, input logic [31:0] rd,
                        input int gd, input int rl, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] ewb);
    valid = 1'b1; is_load = ld; st = ~ld; alu_res = addr; st_wd = wdata; bctl = bc;
    rf_we = ld; rf_wa = wa; wd_pre = addr;
    exp_q.push_back('{we: ld, wa: wa, wd: ld ? ewb : addr, mis: 1'b0});
    for (int c = 0; c <= gd; c++) begin
      gnt = (c == gd);
      @(negedge clk);
      chk("req", {31'b0, req}, 32'd1);
      chk("stall", {31'b0, stall}, {31'b0, (c < gd) || ld});
      if (c == gd) begin
        chk("dmem_a", dm_a, {addr[31:2], 2'b00});
        chk("dmem_be", {28'b0, dm_be}, {28'b0, ebe});
        chk("dmem_we", {31'b0, dm_we}, {31'b0, ~ld});
        if (!ld) chk("dmem_wd", dm_wd, ewd);
      end
      tick();
    end
    gnt = 1'b0;
    if (ld) begin
      for (int k = 1; k <= rl; k++) begin
        rvalid = (k == rl);
        rdata  = (k == rl) ? rd : 32'h5A5A5A5A;
        @(negedge clk);
        chk("rsp_req", {31'b0, req}, 32'd0);
        chk("rsp_stall", {31'b0, stall}, {31'b0, k != rl});
        tick();
      end
      rvalid = 1'b0;
    end
  endtask

  initial begin
    // Reset held two cycles with a load pending: stall follows the inputs.
    valid = 1'b1; is_load = 1'b1; alu_res = 32'h100; bctl = 3'b010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0; is_load = 1'b0;
    tick();

    alu_op(5'd5, 32'h1234);
    idle();
    //     ld    addr         wdata         bc      wa    rd            gd rl be       st wd         load wb
    mem_op(1'b0, 32'h103, 32'h000000AB, 3'b000, 5'd0, 32'h0,         2, 0, 4'b1000, 32'hABABABAB, 32'h0);
    mem_op(1'b1, 32'h102, 32'h0,        3'b001, 5'd7, 32'h80010000,  1, 3, 4'b1100, 32'h0,        32'hFFFF8001);
    mem_op(1'b1, 32'h101, 32'h0,        3'b100, 5'd8, 32'h0000F200,  0, 1, 4'b0010, 32'h0,        32'h000000F2);
    mem_op(1'b1, 32'h104, 32'h0,        3'b010, 5'd9, 32'hDEADBEEF,  0, 2, 4'b1111, 32'h0,        32'hDEADBEEF);
    idle();
    mem_op(1'b0, 32'h102, 32'h1234ABCD, 3'b001, 5'd1, 32'h0,         0, 0, 4'b1100, 32'hABCDABCD, 32'h0);
    mem_op(1'b0, 32'h108, 32'hCAFEF00D, 3'b010, 5'd2, 32'h0,         1, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
    mem_op(1'b1, 32'h102, 32'h0,        3'b000, 5'd10, 32'h00800000, 0, 1, 4'b0100, 32'h0,        32'hFFFFFF80);
    mem_op(1'b1, 32'h100, 32'h0,        3'b101, 5'd11, 32'h1234F00F, 1, 1, 4'b0011, 32'h0,        32'h0000F00F);
    idle();

    // Reset while waiting for rvalid: the late response must not reach MEM/WB.
    valid = 1'b1; is_load = 1'b1; st = 1'b0; alu_res = 32'h100; bctl = 3'b010;
    rf_we = 1'b1; rf_wa = 5'd12; gnt = 1'b1;
    @(negedge clk);
    chk("rr_req", {31'b0, req}, 32'd1);
    tick();
    gnt = 1'b0; rst = 1'b1; valid = 1'b0; is_load = 1'b0;
    tick();
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
    @(negedge clk);
    chk("rr_late_stall", {31'b0, stall}, 32'd0);
    chk("rr_late_req", {31'b0, req}, 32'd0);
    tick();
    rvalid = 1'b0;
    idle();
    alu_op(5'd3, 32'h0000BEEF);

`ifdef RV_LSU_MISALIGN_TRAP_EN
    valid = 1'b1; is_load = 1'b1; st = 1'b0; alu_res = 32'h102; bctl = 3'b010;
    rf_we = 1'b1; rf_wa = 5'd13;
    exp_q.push_back('{we: 1'b0, wa: 5'd0, wd: 32'h0, mis: 1'b1});
    @(negedge clk);
    chk("mis_req", {31'b0, req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    tick();
`endif

    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
